// File: rtl/arm_core_pkg.sv
// Shared ARM-subset core definitions: ALU command encodings, ID/EX control bundle, field widths.
package arm_core_pkg;

    localparam int ARCH_REG_AW = 4;
    localparam int SHIFT_W     = 12;
    localparam int SIMM_W      = 24;
    localparam int CTRL_W      = 9;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exec_cmd_e;

    typedef struct packed {
        exec_cmd_e exec_cmd;
        logic      mem_read;
        logic      mem_write;
        logic      wb_en;
        logic      b_jump;
        logic      update_s;
    } ctrl_t;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async active-low reset, then clear > hold > load on each edge.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_hold,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with freeze, flush and valid tracking.
// Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
    import arm_core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = ARCH_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               freeze,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [3:0]         id_exec_cmd,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_wb_en,
    input  logic               id_b_jump,
    input  logic               id_update_s,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [DATA_W-1:0]  id_val_rn,
    input  logic [DATA_W-1:0]  id_val_rm,
    input  logic               id_imm,
    input  logic [SHIFT_W-1:0] id_shift_op,
    input  logic [SIMM_W-1:0]  id_simm24,
    input  logic [REG_AW-1:0]  id_dest,
    input  logic [REG_AW-1:0]  id_src1,
    input  logic [REG_AW-1:0]  id_src2,
    input  logic               id_carry,
    output logic               ex_valid,
    output logic [3:0]         ex_exec_cmd,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_wb_en,
    output logic               ex_b_jump,
    output logic               ex_update_s,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_val_rn,
    output logic [DATA_W-1:0]  ex_val_rm,
    output logic               ex_imm,
    output logic [SHIFT_W-1:0] ex_shift_op,
    output logic [SIMM_W-1:0]  ex_simm24,
    output logic [REG_AW-1:0]  ex_dest,
    output logic [REG_AW-1:0]  ex_src1,
    output logic [REG_AW-1:0]  ex_src2,
    output logic               ex_carry,
    output logic [CNT_W-1:0]   perf_stall_cnt,
    output logic [CNT_W-1:0]   perf_flush_cnt
);

    localparam int DP_W = 3 * DATA_W + 1 + SHIFT_W + SIMM_W + 3 * REG_AW + 1;

    ctrl_t             w_ctrl_in;
    ctrl_t             w_ctrl_gated;
    ctrl_t             w_ctrl_q;
    logic [CTRL_W:0]   w_ctrl_reg_q;
    logic [DP_W-1:0]   w_dp_d;
    logic [DP_W-1:0]   w_dp_q;

    assign w_ctrl_in.exec_cmd  = exec_cmd_e'(id_exec_cmd);
    assign w_ctrl_in.mem_read  = id_mem_read;
    assign w_ctrl_in.mem_write = id_mem_write;
    assign w_ctrl_in.wb_en     = id_wb_en;
    assign w_ctrl_in.b_jump    = id_b_jump;
    assign w_ctrl_in.update_s  = id_update_s;

    // A bubble must carry no side effects, so its controls are zeroed before capture.
    assign w_ctrl_gated = id_valid ? w_ctrl_in : '0;

    pipe_field_reg #(
        .W(CTRL_W + 1)
    ) u_ctrl_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hold (freeze),
        .i_clear(flush),
        .i_d    ({id_valid, w_ctrl_gated}),
        .o_q    (w_ctrl_reg_q)
    );

    assign w_dp_d = {id_pc, id_val_rn, id_val_rm, id_imm, id_shift_op, id_simm24,
                     id_dest, id_src1, id_src2, id_carry};

    // Datapath is meaningless once flushed, so it simply keeps loading instead of clearing.
    pipe_field_reg #(
        .W(DP_W)
    ) u_dp_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hold (freeze & ~flush),
        .i_clear(1'b0),
        .i_d    (w_dp_d),
        .o_q    (w_dp_q)
    );

    assign ex_valid     = w_ctrl_reg_q[CTRL_W];
    assign w_ctrl_q     = ctrl_t'(w_ctrl_reg_q[CTRL_W-1:0]);
    assign ex_exec_cmd  = w_ctrl_q.exec_cmd;
    assign ex_mem_read  = w_ctrl_q.mem_read;
    assign ex_mem_write = w_ctrl_q.mem_write;
    assign ex_wb_en     = w_ctrl_q.wb_en;
    assign ex_b_jump    = w_ctrl_q.b_jump;
    assign ex_update_s  = w_ctrl_q.update_s;

    assign {ex_pc, ex_val_rn, ex_val_rm, ex_imm, ex_shift_op, ex_simm24,
            ex_dest, ex_src1, ex_src2, ex_carry} = w_dp_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_kill_valid;

    // The instruction a flush kills is the held one under freeze, otherwise the incoming one.
    assign w_kill_valid = flush & (freeze ? ex_valid : id_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (freeze && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_kill_valid && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed vector table, reset corner cases, counter saturation,
// and randomized traffic against a behavioural model.
module tb_id_ex_stage_reg;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       vld;
        logic [3:0] cmd;
        logic       mr, mw, wb, bj, us;
    } ctrl_o_t;

    typedef struct packed {
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] off;
        logic [3:0]  dst, s1, s2;
        logic        c;
    } dp_t;

    typedef struct packed {
        logic       frz, fls, vld;
        logic [3:0] cmd;
        logic       mr, mw, wb, bj, us;
        dp_t        dp;
    } in_t;

    typedef struct {
        string   nm;
        in_t     in;
        ctrl_o_t ec;
        bit      dpchk;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic freeze, flush, id_valid;
    logic [3:0] id_exec_cmd;
    logic id_mem_read, id_mem_write, id_wb_en, id_b_jump, id_update_s;
    logic [31:0] id_pc, id_val_rn, id_val_rm;
    logic id_imm;
    logic [11:0] id_shift_op;
    logic [23:0] id_simm24;
    logic [3:0] id_dest, id_src1, id_src2;
    logic id_carry;
    logic ex_valid;
    logic [3:0] ex_exec_cmd;
    logic ex_mem_read, ex_mem_write, ex_wb_en, ex_b_jump, ex_update_s;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic ex_imm;
    logic [11:0] ex_shift_op;
    logic [23:0] ex_simm24;
    logic [3:0] ex_dest, ex_src1, ex_src2;
    logic ex_carry;
    logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_o_t m_ctrl;
    dp_t     m_dp;
    bit      m_dp_known;
    int      m_stall, m_flush;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_exec_cmd(id_exec_cmd), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_wb_en(id_wb_en), .id_b_jump(id_b_jump), .id_update_s(id_update_s),
        .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
        .id_shift_op(id_shift_op), .id_simm24(id_simm24), .id_dest(id_dest),
        .id_src1(id_src1), .id_src2(id_src2), .id_carry(id_carry),
        .ex_valid(ex_valid), .ex_exec_cmd(ex_exec_cmd), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en), .ex_b_jump(ex_b_jump),
        .ex_update_s(ex_update_s), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn),
        .ex_val_rm(ex_val_rm), .ex_imm(ex_imm), .ex_shift_op(ex_shift_op),
        .ex_simm24(ex_simm24), .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_carry(ex_carry), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    function automatic ctrl_o_t act_ctrl();
        return {ex_valid, ex_exec_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_b_jump, ex_update_s};
    endfunction

    function automatic dp_t act_dp();
        return {ex_pc, ex_val_rn, ex_val_rm, ex_imm, ex_shift_op, ex_simm24,
                ex_dest, ex_src1, ex_src2, ex_carry};
    endfunction

    function automatic in_t mk(bit frz, bit fls, bit vld, logic [3:0] cmd, bit mr, bit mw, bit wb,
                               logic [31:0] pc, logic [31:0] rn, logic [31:0] rm, logic [3:0] dst);
        in_t r;
        r = '0;
        r.frz = frz; r.fls = fls; r.vld = vld; r.cmd = cmd;
        r.mr = mr; r.mw = mw; r.wb = wb;
        r.dp.pc = pc; r.dp.rn = rn; r.dp.rm = rm; r.dp.imm = rn[0];
        r.dp.sh = rm[11:0] ^ 12'hA5A; r.dp.off = pc[23:0] + 24'h100;
        r.dp.dst = dst; r.dp.s1 = dst + 4'd1; r.dp.s2 = dst + 4'd2; r.dp.c = 1'b1;
        return r;
    endfunction

    function automatic ctrl_o_t ec(bit vld, logic [3:0] cmd, bit mr, bit mw, bit wb);
        return ctrl_o_t'({vld, cmd, mr, mw, wb, 1'b0, 1'b0});
    endfunction

    task automatic chk_ctrl(string nm, ctrl_o_t exp);
        n_checks++;
        if (act_ctrl() !== exp) begin
            n_errors++;
            $display("FAIL %s ctrl: got %h expected %h", nm, act_ctrl(), exp);
        end
    endtask

    task automatic chk_dp(string nm, dp_t exp);
        n_checks++;
        if (act_dp() !== exp) begin
            n_errors++;
            $display("FAIL %s datapath: got %h expected %h", nm, act_dp(), exp);
        end
    endtask

    task automatic chk_val(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_perf(string nm);
`ifdef ID_EX_PERF_CNT_EN
        chk_val({nm, " stall_cnt"}, 32'(perf_stall_cnt), 32'(m_stall));
        chk_val({nm, " flush_cnt"}, 32'(perf_flush_cnt), 32'(m_flush));
`else
        chk_val({nm, " stall_cnt"}, 32'(perf_stall_cnt), 32'd0);
        chk_val({nm, " flush_cnt"}, 32'(perf_flush_cnt), 32'd0);
`endif
    endtask

    task automatic drive(in_t in);
        freeze = in.frz; flush = in.fls; id_valid = in.vld; id_exec_cmd = in.cmd;
        id_mem_read = in.mr; id_mem_write = in.mw; id_wb_en = in.wb;
        id_b_jump = in.bj; id_update_s = in.us;
        id_pc = in.dp.pc; id_val_rn = in.dp.rn; id_val_rm = in.dp.rm; id_imm = in.dp.imm;
        id_shift_op = in.dp.sh; id_simm24 = in.dp.off; id_dest = in.dp.dst;
        id_src1 = in.dp.s1; id_src2 = in.dp.s2; id_carry = in.dp.c;
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_dp = '0; m_dp_known = 1'b1; m_stall = 0; m_flush = 0;
    endtask

    // The register's job: kill on flush, keep on freeze, otherwise take ID (controls only if valid).
    task automatic model_step(in_t in);
        bit killed_valid;
        killed_valid = in.frz ? m_ctrl.vld : in.vld;
        if (in.frz && m_stall < CNT_MAX) m_stall++;
        if (in.fls) begin
            if (killed_valid && m_flush < CNT_MAX) m_flush++;
            m_ctrl = '0;
            m_dp_known = 1'b0;
        end else if (!in.frz) begin
            m_ctrl = in.vld ? ctrl_o_t'({1'b1, in.cmd, in.mr, in.mw, in.wb, in.bj, in.us}) : '0;
            m_dp = in.dp;
            m_dp_known = 1'b1;
        end
    endtask

    task automatic apply(in_t in);
        drive(in);
        @(posedge clk);
        model_step(in);
        #1;
    endtask

    in_t  add_i, str_i, ldr_i, mov_i, rin;
    vec_t vecs[$];

    initial begin
        add_i = mk(0, 0, 1, 4'b0010, 0, 0, 1, 32'h0000_0010, 32'd5, 32'd7, 4'd3);
        str_i = mk(0, 0, 1, 4'b0010, 0, 1, 0, 32'h0000_0014, 32'd8, 32'd9, 4'd4);
        ldr_i = mk(0, 1, 1, 4'b0010, 1, 0, 1, 32'h0000_0018, 32'd11, 32'd12, 4'd5);
        mov_i = mk(1, 1, 1, 4'b0001, 0, 0, 1, 32'h0000_001C, 32'd13, 32'd14, 4'd6);
        vecs.push_back('{"load_add", add_i, ec(1, 4'b0010, 0, 0, 1), 1});
        for (int k = 0; k < 3; k++) begin
            in_t f;
            f = str_i; f.frz = 1'b1; f.dp.rn = str_i.dp.rn + 32'(k);
            vecs.push_back('{"freeze_hold", f, ec(1, 4'b0010, 0, 0, 1), 1});
        end
        vecs.push_back('{"release_str", str_i, ec(1, 4'b0010, 0, 1, 0), 1});
        vecs.push_back('{"flush_ldr", ldr_i, ec(0, 4'b0000, 0, 0, 0), 0});
        vecs.push_back('{"reload_add", add_i, ec(1, 4'b0010, 0, 0, 1), 1});
        vecs.push_back('{"flush_freeze_mov", mov_i, ec(0, 4'b0000, 0, 0, 0), 0});
        rin = mov_i; rin.frz = 1'b1; rin.fls = 1'b0;
        vecs.push_back('{"freeze_after_flush", rin, ec(0, 4'b0000, 0, 0, 0), 0});
        rin = add_i; rin.vld = 1'b0;
        vecs.push_back('{"bubble_load", rin, ec(0, 4'b0000, 0, 0, 0), 1});
        vecs.push_back('{"final_add", add_i, ec(1, 4'b0010, 0, 0, 1), 1});

        drive(add_i);
        model_reset();
        #12;
        chk_ctrl("reset_ctrl", '0);
        chk_dp("reset_dp", '0);
        chk_perf("reset");
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].in);
            chk_ctrl(vecs[i].nm, vecs[i].ec);
            if (vecs[i].dpchk) chk_dp(vecs[i].nm, vecs[i].in.frz ? add_i.dp : vecs[i].in.dp);
            chk_perf(vecs[i].nm);
        end

        // Asynchronous reset mid-cycle while ex_wb_en is set.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_ctrl("async_reset_ctrl", '0);
        chk_dp("async_reset_dp", '0);

        // Reset held across edges with freeze and flush asserted, then a normal load.
        drive(mov_i);
        repeat (2) @(posedge clk);
        #1 chk_ctrl("reset_over_flush_freeze", '0);
        @(negedge clk) rst_n = 1'b1;
        apply(add_i);
        chk_ctrl("post_reset_load", ec(1, 4'b0010, 0, 0, 1));
        chk_dp("post_reset_load", add_i.dp);

        // Stall counter saturation over 20 freeze cycles.
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        rin = str_i; rin.frz = 1'b1;
        repeat (20) apply(rin);
`ifdef ID_EX_PERF_CNT_EN
        chk_val("stall_saturate", 32'(perf_stall_cnt), 32'd15);
`else
        chk_val("stall_disabled", 32'(perf_stall_cnt), 32'd0);
`endif
        chk_ctrl("stall_hold_empty", '0);

        for (int i = 0; i < 400; i++) begin
            rin = '0;
            rin.frz = ($urandom_range(0, 3) == 0);
            rin.fls = ($urandom_range(0, 5) == 0);
            rin.vld = ($urandom_range(0, 3) != 0);
            rin.cmd = 4'($urandom_range(0, 9));
            {rin.mr, rin.mw, rin.wb, rin.bj, rin.us} = 5'($urandom);
            rin.dp.pc = $urandom; rin.dp.rn = $urandom; rin.dp.rm = $urandom;
            {rin.dp.imm, rin.dp.sh, rin.dp.off} = 37'({$urandom, $urandom});
            {rin.dp.dst, rin.dp.s1, rin.dp.s2, rin.dp.c} = 13'($urandom);
            apply(rin);
            chk_ctrl("random", m_ctrl);
            if (m_dp_known) chk_dp("random", m_dp);
            if (i % 16 == 15) chk_perf("random");
            if (!ex_valid) begin
                n_checks++;
                if ({ex_mem_write, ex_wb_en, ex_b_jump, ex_update_s} !== 4'b0) begin
                    n_errors++;
                    $display("FAIL invalid_side_effects: got %b expected 0000",
                             {ex_mem_write, ex_wb_en, ex_b_jump, ex_update_s});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
